// File: rtl/ro_freq_counter.sv
// Gated edge counter for a divided ring-oscillator tap, synchronised into clk.
// Define RO_FREQ_CONT_EN for continuous back-to-back measurement windows.
module ro_freq_counter #(
   parameter int CNT_WIDTH   = 16,
   parameter int GATE_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  ro_in,
   input  logic                  start,
   input  logic [GATE_WIDTH-1:0] gate_cycles,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  valid,
   output logic                  done,
   output logic                  busy,
   output logic                  overflow
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_prev;
   logic                   rise;
   logic [1:0]             state;
   logic [GATE_WIDTH-1:0]  timer;
   logic [CNT_WIDTH-1:0]   acc;
   logic [CNT_WIDTH-1:0]   acc_nxt;
   logic                   acc_full;
   logic                   ovf;
   logic                   ovf_nxt;
`ifdef RO_FREQ_CONT_EN
   logic [GATE_WIDTH-1:0]  gate_lat;
`endif

   // s_prev tracks s in every state so entering MEASURE never fakes an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
         s_prev <= s;
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign rise     = s & ~s_prev;
   assign acc_full = &acc;
   assign acc_nxt  = (rise && !acc_full) ? acc + CNT_WIDTH'(1) : acc;
   assign ovf_nxt  = ovf | (rise & acc_full);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         timer    <= '0;
         acc      <= '0;
         ovf      <= 1'b0;
         count    <= '0;
         valid    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         overflow <= 1'b0;
`ifdef RO_FREQ_CONT_EN
         gate_lat <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && ena && gate_cycles != '0) begin
                  timer    <= gate_cycles;
                  acc      <= '0;
                  ovf      <= 1'b0;
                  valid    <= 1'b0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_MEASURE;
`ifdef RO_FREQ_CONT_EN
                  gate_lat <= gate_cycles;
`endif
               end
            end
            ST_MEASURE: begin
               if (!ena) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  acc   <= acc_nxt;
                  ovf   <= ovf_nxt;
                  timer <= timer - GATE_WIDTH'(1);
                  // last window cycle: its own rise is folded into the result
                  if (timer == GATE_WIDTH'(1)) begin
                     count    <= acc_nxt;
                     overflow <= ovf_nxt;
                     valid    <= 1'b1;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     state    <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
`ifdef RO_FREQ_CONT_EN
               if (ena) begin
                  timer <= gate_lat;
                  acc   <= '0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_MEASURE;
               end else begin
                  state <= ST_IDLE;
               end
`else
               state <= ST_IDLE;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Randomised and directed bench for ro_freq_counter against a window-level model.
// Two instances share stimulus: a wide one and a narrow one that saturates easily.
module tb_ro_freq_counter;

   localparam int HMAX = 16384;
   localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        ro_in = 1'b0;
   logic        start = 1'b0;
   logic [15:0] gate_cycles = '0;

   logic [15:0] count0;
   logic        valid0, done0, busy0, ovf0;
   logic [3:0]  count1;
   logic        valid1, done1, busy1, ovf1;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 0;

   int ro_period = 10;
   bit ro_level = 0;
   int ro_ph = 0;

   always #5 clk = ~clk;

   ro_freq_counter #(.CNT_WIDTH(16), .GATE_WIDTH(16), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
      .gate_cycles(gate_cycles), .count(count0), .valid(valid0), .done(done0),
      .busy(busy0), .overflow(ovf0));

   ro_freq_counter #(.CNT_WIDTH(4), .GATE_WIDTH(8), .SYNC_STAGES(3)) u_sat (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
      .gate_cycles(gate_cycles[7:0]), .count(count1), .valid(valid1), .done(done1),
      .busy(busy1), .overflow(ovf1));

   // ---------------- reference model ----------------
   // ro_in history per instance: s at edge n is ro_in sampled S edges earlier
   bit     hist [2][HMAX];
   int     nedge = 0;
   int     m_ph [2];
   int     m_rem [2];
   int     m_glat [2];
   longint m_rises [2];
   longint m_count [2];
   bit     m_valid [2], m_done [2], m_busy [2], m_ovf [2];

   function automatic int sstages(input int i);
      return (i == 0) ? 2 : 3;
   endfunction
   function automatic longint cmax(input int i);
      return (i == 0) ? 64'd65535 : 64'd15;
   endfunction
   function automatic int gval(input int i, input logic [15:0] g);
      return (i == 0) ? int'(g) : int'(g[7:0]);
   endfunction
   function automatic bit h(input int i, input int j);
      return (j < 0 || j >= HMAX) ? 1'b0 : hist[i][j];
   endfunction

   always @(posedge clk) begin : model
      bit rs;
      int g;
      for (int i = 0; i < 2; i++) begin
         rs = h(i, nedge - sstages(i)) & ~h(i, nedge - sstages(i) - 1);
         g  = gval(i, gate_cycles);
         if (nedge < HMAX) hist[i][nedge] = ro_in;
         if (!rst_n) begin
            for (int j = nedge - sstages(i); j <= nedge; j++)
               if (j >= 0 && j < HMAX) hist[i][j] = 1'b0;
            m_ph[i] = P_IDLE; m_count[i] = 0; m_valid[i] = 0;
            m_done[i] = 0; m_busy[i] = 0; m_ovf[i] = 0;
         end else begin
            m_done[i] = 0;
            case (m_ph[i])
               P_IDLE: if (start && ena && g != 0) begin
                  m_rem[i] = g; m_glat[i] = g; m_rises[i] = 0;
                  m_valid[i] = 0; m_ovf[i] = 0; m_busy[i] = 1; m_ph[i] = P_RUN;
               end
               P_RUN: if (!ena) begin
                  m_busy[i] = 0; m_ph[i] = P_IDLE;
               end else begin
                  m_rises[i] += rs;
                  m_rem[i]--;
                  if (m_rem[i] == 0) begin
                     m_count[i] = (m_rises[i] > cmax(i)) ? cmax(i) : m_rises[i];
                     m_ovf[i]   = m_rises[i] > cmax(i);
                     m_valid[i] = 1; m_done[i] = 1; m_busy[i] = 0; m_ph[i] = P_DONE;
                  end
               end
               default: begin
`ifdef RO_FREQ_CONT_EN
                  if (ena) begin
                     m_rem[i] = m_glat[i]; m_rises[i] = 0; m_busy[i] = 1; m_ph[i] = P_RUN;
                  end else m_ph[i] = P_IDLE;
`else
                  m_ph[i] = P_IDLE;
`endif
               end
            endcase
         end
      end
      nedge++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if ({count0, valid0, done0, busy0, ovf0} !==
             {16'(m_count[0]), m_valid[0], m_done[0], m_busy[0], m_ovf[0]}) begin
            n_fail++;
            $display("FAIL model_wide t=%0t got cnt=%0d v=%b d=%b b=%b o=%b want cnt=%0d v=%b d=%b b=%b o=%b",
                     $time, count0, valid0, done0, busy0, ovf0,
                     m_count[0], m_valid[0], m_done[0], m_busy[0], m_ovf[0]);
         end
         n_chk++;
         if ({count1, valid1, done1, busy1, ovf1} !==
             {4'(m_count[1]), m_valid[1], m_done[1], m_busy[1], m_ovf[1]}) begin
            n_fail++;
            $display("FAIL model_narrow t=%0t got cnt=%0d v=%b d=%b b=%b o=%b want cnt=%0d v=%b d=%b b=%b o=%b",
                     $time, count1, valid1, done1, busy1, ovf1,
                     m_count[1], m_valid[1], m_done[1], m_busy[1], m_ovf[1]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic ro_drive();
      forever begin
         @(negedge clk);
         if (ro_period == 0) ro_in = ro_level;
         else begin
            ro_ph = (ro_ph + 1) % ro_period;
            ro_in = (ro_ph < ro_period / 2);
         end
      end
   endtask

   task automatic measure(input int g, input int ncyc, output int nb0, output int nb1, output int nd);
      start = 1'b1; gate_cycles = 16'(g);
      @(negedge clk);
      start = 1'b0;
      nb0 = 0; nb1 = 0; nd = 0;
      for (int i = 0; i < ncyc; i++) begin
         nb0 += busy0; nb1 += busy1; nd += done0;
         @(negedge clk);
      end
   endtask

   initial begin
      int nb0, nb1, nd, r;
      fork ro_drive(); join_none
      @(negedge clk);
      chk_en = 1;
      repeat (2) @(negedge clk);
      chk("reset_count", 32'(count0), 0);
      chk("reset_valid", 32'(valid0), 0);
      chk("reset_busy", 32'(busy0), 0);
      chk("reset_done", 32'(done0), 0);
      chk("reset_ovf", 32'(ovf0), 0);
      rst_n = 1'b1; ena = 1'b1;
      repeat (30) @(negedge clk);

`ifdef RO_FREQ_CONT_EN
      begin
         int last, ndn;
         ro_period = 8;
         repeat (20) @(negedge clk);
         start = 1'b1; gate_cycles = 16'd64;
         @(negedge clk);
         start = 1'b0;
         last = -1; ndn = 0;
         for (int i = 0; i < 300; i++) begin
            if (i == 100) gate_cycles = 16'd10;
            if (done0) begin
               chk("cont_count", 32'(count0), 8);
               if (last >= 0) chk("cont_period", 32'(i - last), 65);
               last = i; ndn++;
            end
            @(negedge clk);
         end
         chk("cont_done_num", 32'(ndn), 4);
         ena = 1'b0;
         @(negedge clk);
         chk("cont_abort_busy", 32'(busy0), 0);
         ena = 1'b1;
         repeat (5) @(negedge clk);
      end
`else
      measure(100, 110, nb0, nb1, nd);
      chk("single_busy_cycles", 32'(nb0), 100);
      chk("single_done_pulses", 32'(nd), 1);
      chk("single_count", 32'(count0), 10);
      chk("single_valid", 32'(valid0), 1);
      chk("single_ovf", 32'(ovf0), 0);

      measure(0, 20, nb0, nb1, nd);
      chk("zero_busy", 32'(nb0), 0);
      chk("zero_done", 32'(nd), 0);
      chk("zero_count_hold", 32'(count0), 10);
      chk("zero_valid_hold", 32'(valid0), 1);

      ro_period = 4;
      repeat (20) @(negedge clk);
      measure(100, 110, nb0, nb1, nd);
      chk("sat_count", 32'(count1), 15);
      chk("sat_ovf", 32'(ovf1), 1);
      chk("sat_valid", 32'(valid1), 1);
      chk("wide_count_25", 32'(count0), 25);
      chk("wide_ovf", 32'(ovf0), 0);

      start = 1'b1; gate_cycles = 16'd100;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy0), 0);
      chk("abort_valid", 32'(valid0), 0);
      chk("abort_done", 32'(done0), 0);
      chk("abort_count_hold", 32'(count0), 25);
      ena = 1'b1;
      repeat (5) @(negedge clk);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_count", 32'(count0), 0);
      chk("midrst_busy", 32'(busy0), 0);
      chk("midrst_valid", 32'(valid0), 0);
      chk("midrst_ovf", 32'(ovf1), 0);
      rst_n = 1'b1;

      ro_period = 0; ro_level = 1'b1;
      repeat (10) @(negedge clk);
      start = 1'b1; gate_cycles = 16'd50;
      @(negedge clk);
      nd = 0;
      for (int i = 0; i < 60; i++) begin
         start = (i == 20);
         nd += done0;
         @(negedge clk);
      end
      start = 1'b0;
      chk("quiet_done_once", 32'(nd), 1);
      chk("quiet_count", 32'(count0), 0);
      chk("quiet_valid", 32'(valid0), 1);

      ro_period = 5;
      repeat (20) @(negedge clk);
      measure(255, 265, nb0, nb1, nd);
      chk("gate_max_busy_narrow", 32'(nb1), 255);
      chk("gate255_count", 32'(count0), 51);
      chk("gate_max_sat", 32'(count1), 15);
`endif

      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            r = $urandom_range(0, 12);
            if (r < 3) begin ro_period = 0; ro_level = 1'($urandom_range(0, 1)); end
            else ro_period = r;
         end
         start = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 5))
            0: gate_cycles = 16'd0;
            1: gate_cycles = 16'd1;
            2: gate_cycles = 16'd2;
            default: gate_cycles = 16'($urandom_range(3, 60));
         endcase
         ena   = ($urandom_range(0, 199) != 0);
         rst_n = ($urandom_range(0, 599) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1; ena = 1'b1; start = 1'b0;
      repeat (5) @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
